// File: rtl/game_pkg.sv
// Shared definitions for the game round controller.
//   game_state_e : round FSM state encoding (also exported on state_o)
//   SCORE_W      : width of score / lb_score
//   TIME_W       : width of time_left
//   sat_inc      : score increment that sticks at all-ones
package game_pkg;

    localparam int unsigned SCORE_W = 8;
    localparam int unsigned TIME_W  = 8;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StReady  = 3'd1,
        StPlay   = 3'd2,
        StCommit = 3'd3,
        StDone   = 3'd4
    } game_state_e;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (&v) ? v : v + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/hoop_debounce.sv
// Hoop switch conditioner: 2-flop synchronizer, stability filter and rising-edge pulse.
//   clock  : system clock
//   reset  : synchronous, active-low; clears synchronizer, filter and counter
//   raw_i  : raw asynchronous, bouncy switch (1 = ball in hoop)
//   hit_o  : registered 1-cycle pulse when the filtered level goes 0->1
// The filtered level only follows the synced input after DEBOUNCE_CYC consecutive cycles of
// disagreement, so raw->hit latency is 2 + DEBOUNCE_CYC cycles.
module hoop_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 500_000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_i,
    output logic hit_o
);

    localparam int unsigned CntW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYC - 1);

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            level_q, level_d;
    logic            hit_q, hit_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = raw_i;
        sync2_d = sync1_q;
        level_d = level_q;
        hit_d   = 1'b0;
        cnt_d   = '0;
        // Any cycle where the synced value agrees with the filter restarts the count.
        if (sync2_q != level_q) begin
            if (cnt_q == CntLast) begin
                level_d = sync2_q;
                hit_d   = sync2_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            hit_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            hit_q   <= hit_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hit_o = hit_q;

endmodule

// File: rtl/game_round_controller.sv
// Sequences one timed basketball round: ready countdown, per-second round timer, debounced
// hoop scoring, and a valid/ready commit of the final score to the leaderboard.
//   clock, reset : system clock; synchronous active-low reset
//   start_btn    : raw start request (rising edge after sync starts a round)
//   hoop_sw      : raw hoop switch, debounced internally
//   lb_ready     : leaderboard accepts lb_score when lb_valid=1
//   lb_valid     : final score offered; lb_score stable while high
//   score        : live score of the current/last round
//   time_left    : seconds remaining (ready count in READY, round count in PLAY)
//   playing      : 1 only in PLAY
//   game_over    : 1 only in DONE
//   state_o      : current state encoding
// All outputs come straight from flops.
module game_round_controller
    import game_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 50_000_000,
    parameter int unsigned ROUND_SECS   = 10,
    parameter int unsigned READY_SECS   = 3,
    parameter int unsigned DEBOUNCE_CYC = 500_000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start_btn,
    input  logic               hoop_sw,
    input  logic               lb_ready,
    output logic               lb_valid,
    output logic [SCORE_W-1:0] lb_score,
    output logic [SCORE_W-1:0] score,
    output logic [TIME_W-1:0]  time_left,
    output logic               playing,
    output logic               game_over,
    output logic [2:0]         state_o
);

    localparam int unsigned     PreW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PreW-1:0] PreLast   = PreW'(TICK_DIV - 1);
    localparam logic [TIME_W-1:0] RoundSecs = TIME_W'(ROUND_SECS);
    localparam logic [TIME_W-1:0] ReadySecs = TIME_W'(READY_SECS);

    game_state_e        state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [TIME_W-1:0]  time_q, time_d;
    logic               lbv_q, lbv_d;
    logic [SCORE_W-1:0] lbs_q, lbs_d;
    logic               playing_q, playing_d;
    logic               game_over_q, game_over_d;
    logic [PreW-1:0]    presc_q, presc_d;
    logic               start_s1_q, start_s2_q, start_s3_q;

    logic               start_edge;
    logic               tick;
    logic               hit;
    logic [SCORE_W-1:0] score_inc;

    hoop_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_hoop_debounce (
        .clock(clock),
        .reset(reset),
        .raw_i(hoop_sw),
        .hit_o(hit)
    );

    assign start_edge = start_s2_q & ~start_s3_q;
    assign tick       = (presc_q == PreLast);
    // Score including a hit in this cycle; lets a hit on the final tick reach lb_score.
    assign score_inc  = hit ? sat_inc(score_q) : score_q;

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        time_d  = time_q;
        lbv_d   = lbv_q;
        lbs_d   = lbs_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start_edge) begin
                    state_d = StReady;
                    time_d  = ReadySecs;
                    score_d = '0;
                end
            end
            StReady: begin
                if (tick) begin
                    if (time_q == TIME_W'(1)) begin
                        state_d = StPlay;
                        time_d  = RoundSecs;
                    end else begin
                        time_d = time_q - TIME_W'(1);
                    end
                end
            end
            StPlay: begin
                score_d = score_inc;
                if (tick) begin
                    if (time_q == TIME_W'(1)) begin
                        state_d = StCommit;
                        time_d  = '0;
                        lbv_d   = 1'b1;
                        lbs_d   = score_inc;
                    end else begin
                        time_d = time_q - TIME_W'(1);
                    end
                end
            end
            StCommit: begin
                if (lb_ready) begin
                    state_d = StDone;
                    lbv_d   = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Restart the second timer whenever a timed state is entered.
        if ((state_d != state_q) && (state_d == StReady || state_d == StPlay)) begin
            presc_d = '0;
        end else if (tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PreW'(1);
        end

        playing_d   = (state_d == StPlay);
        game_over_d = (state_d == StDone);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= StIdle;
            score_q     <= '0;
            time_q      <= RoundSecs;
            lbv_q       <= 1'b0;
            lbs_q       <= '0;
            playing_q   <= 1'b0;
            game_over_q <= 1'b0;
            presc_q     <= '0;
            start_s1_q  <= 1'b0;
            start_s2_q  <= 1'b0;
            start_s3_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            time_q      <= time_d;
            lbv_q       <= lbv_d;
            lbs_q       <= lbs_d;
            playing_q   <= playing_d;
            game_over_q <= game_over_d;
            presc_q     <= presc_d;
            start_s1_q  <= start_btn;
            start_s2_q  <= start_s1_q;
            start_s3_q  <= start_s2_q;
        end
    end

    assign lb_valid  = lbv_q;
    assign lb_score  = lbs_q;
    assign score     = score_q;
    assign time_left = time_q;
    assign playing   = playing_q;
    assign game_over = game_over_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_game_round_controller.sv
// Bench for game_round_controller. Three instances with different parameters:
//   0: TICK_DIV=10,  DEBOUNCE_CYC=4, ROUND_SECS=3, READY_SECS=2 (reference timing)
//   1: TICK_DIV=100, DEBOUNCE_CYC=4, ROUND_SECS=3, READY_SECS=2 (room for many slow hits)
//   2: TICK_DIV=400, DEBOUNCE_CYC=1, ROUND_SECS=5, READY_SECS=2 (score saturation)
// Inputs change just after a falling edge; outputs are sampled on falling edges.
module tb_game_round_controller;
    import game_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic [2:0]      rst_n, start_b, hoop_b, lb_rdy;
    logic [2:0]      lbv, pl, go;
    logic [2:0][7:0] lbs, sc, tl;
    logic [2:0][2:0] so;

    game_round_controller #(
        .TICK_DIV(10), .ROUND_SECS(3), .READY_SECS(2), .DEBOUNCE_CYC(4)
    ) u_dut0 (
        .clock(clock), .reset(rst_n[0]), .start_btn(start_b[0]), .hoop_sw(hoop_b[0]),
        .lb_ready(lb_rdy[0]), .lb_valid(lbv[0]), .lb_score(lbs[0]), .score(sc[0]),
        .time_left(tl[0]), .playing(pl[0]), .game_over(go[0]), .state_o(so[0])
    );

    game_round_controller #(
        .TICK_DIV(100), .ROUND_SECS(3), .READY_SECS(2), .DEBOUNCE_CYC(4)
    ) u_dut1 (
        .clock(clock), .reset(rst_n[1]), .start_btn(start_b[1]), .hoop_sw(hoop_b[1]),
        .lb_ready(lb_rdy[1]), .lb_valid(lbv[1]), .lb_score(lbs[1]), .score(sc[1]),
        .time_left(tl[1]), .playing(pl[1]), .game_over(go[1]), .state_o(so[1])
    );

    game_round_controller #(
        .TICK_DIV(400), .ROUND_SECS(5), .READY_SECS(2), .DEBOUNCE_CYC(1)
    ) u_dut2 (
        .clock(clock), .reset(rst_n[2]), .start_btn(start_b[2]), .hoop_sw(hoop_b[2]),
        .lb_ready(lb_rdy[2]), .lb_valid(lbv[2]), .lb_score(lbs[2]), .score(sc[2]),
        .time_left(tl[2]), .playing(pl[2]), .game_over(go[2]), .state_o(so[2])
    );

    typedef struct {
        string      name;
        int         d;
        logic [2:0] st;
        logic [7:0] sc;
        logic [7:0] tl;
        bit         v;
        bit         chk_lbs;
        logic [7:0] lbs;
    } exp_t;

    typedef struct {
        string      name;
        bit         rst;
        bit         st;
        bit         hp;
        bit         rdy;
        int         n;
        logic [2:0] est;
        int         sc;
        int         tl;
        bit         v;
        bit         chk;
        int         lbs;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void add(string name, bit rst, bit st, bit hp, bit rdy, int n,
                                logic [2:0] est, int e_sc, int e_tl, bit v, bit chk, int e_lbs);
        vec_t r;
        r.name = name; r.rst = rst; r.st = st; r.hp = hp; r.rdy = rdy; r.n = n;
        r.est = est; r.sc = e_sc; r.tl = e_tl; r.v = v; r.chk = chk; r.lbs = e_lbs;
        tbl.push_back(r);
    endfunction

    task automatic check_pop();
        exp_t e;
        bit   bad;
        bit   e_pl, e_go;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL sb_empty: got empty scoreboard, want an expected entry");
            return;
        end
        e    = exp_q.pop_front();
        e_pl = (e.st == 3'd2);
        e_go = (e.st == 3'd4);
        bad  = (so[e.d] !== e.st) || (sc[e.d] !== e.sc) || (tl[e.d] !== e.tl) ||
               (lbv[e.d] !== e.v) || (pl[e.d] !== e_pl) || (go[e.d] !== e_go) ||
               (e.chk_lbs && (lbs[e.d] !== e.lbs));
        if (bad) begin
            n_bad++;
            $display("FAIL %s (dut%0d): got st=%0d sc=%0d tl=%0d v=%0b lbs=%0d go=%0b pl=%0b; want st=%0d sc=%0d tl=%0d v=%0b lbs=%0d(chk=%0b) go=%0b pl=%0b",
                     e.name, e.d, so[e.d], sc[e.d], tl[e.d], lbv[e.d], lbs[e.d], go[e.d], pl[e.d],
                     e.st, e.sc, e.tl, e.v, e.lbs, e.chk_lbs, e_go, e_pl);
        end
    endtask

    // Push the expectation for dut d, let n clocks elapse, then compare.
    task automatic run(string name, int d, int n, logic [2:0] est, int e_sc, int e_tl,
                       bit v, bit chk, int e_lbs);
        exp_t e;
        e.name = name; e.d = d; e.st = est; e.sc = 8'(e_sc); e.tl = 8'(e_tl);
        e.v = v; e.chk_lbs = chk; e.lbs = 8'(e_lbs);
        exp_q.push_back(e);
        repeat (n) @(negedge clock);
        check_pop();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by t=200000, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = '0; start_b = '0; hoop_b = '0; lb_rdy = '0;

        // name, rst, start, hoop, lb_ready, cycles, state, score, time_left, lb_valid, chk, lb_score
        add("reset",            0, 0, 0, 0, 2,  StIdle,   0, 3, 0, 1, 0);
        add("idle_hit_ignored", 1, 0, 1, 0, 8,  StIdle,   0, 3, 0, 1, 0);
        add("idle_hoop_low",    1, 0, 0, 0, 8,  StIdle,   0, 3, 0, 1, 0);
        add("start_to_ready",   1, 1, 0, 0, 3,  StReady,  0, 2, 0, 1, 0);
        add("ready_hold2",      1, 1, 0, 0, 9,  StReady,  0, 2, 0, 1, 0);
        add("ready_tick1",      1, 1, 0, 0, 1,  StReady,  0, 1, 0, 1, 0);
        add("ready_hold1",      1, 1, 0, 0, 9,  StReady,  0, 1, 0, 1, 0);
        add("ready_to_play",    1, 1, 0, 0, 1,  StPlay,   0, 3, 0, 1, 0);
        add("play_release",     1, 0, 0, 0, 5,  StPlay,   0, 3, 0, 1, 0);
        add("play_repress_ign", 1, 1, 0, 0, 5,  StPlay,   0, 2, 0, 1, 0);
        add("play_tl1",         1, 0, 0, 0, 10, StPlay,   0, 1, 0, 1, 0);
        add("play_hold1",       1, 0, 0, 0, 9,  StPlay,   0, 1, 0, 1, 0);
        add("play_to_commit",   1, 0, 0, 0, 1,  StCommit, 0, 0, 1, 1, 0);
        add("commit_wait",      1, 0, 0, 0, 7,  StCommit, 0, 0, 1, 1, 0);
        add("commit_to_done",   1, 0, 0, 1, 1,  StDone,   0, 0, 0, 0, 0);
        add("done_rdy_ignored", 1, 0, 0, 1, 4,  StDone,   0, 0, 0, 0, 0);
        add("done_restart",     1, 1, 0, 0, 3,  StReady,  0, 2, 0, 0, 0);
        add("reset_in_ready",   0, 0, 0, 0, 1,  StIdle,   0, 3, 0, 1, 0);
        add("idle_after_reset", 1, 0, 0, 0, 2,  StIdle,   0, 3, 0, 1, 0);

        @(negedge clock);
        foreach (tbl[i]) begin
            rst_n[0] = tbl[i].rst; start_b[0] = tbl[i].st;
            hoop_b[0] = tbl[i].hp; lb_rdy[0] = tbl[i].rdy;
            run(tbl[i].name, 0, tbl[i].n, tbl[i].est, tbl[i].sc, tbl[i].tl,
                tbl[i].v, tbl[i].chk, tbl[i].lbs);
        end

        // Hit filtered exactly on the final PLAY tick; hits in COMMIT/DONE ignored.
        start_b[0] = 1;
        run("a_ready", 0, 3, StReady, 0, 2, 0, 0, 0);
        run("a_last_sec", 0, 43, StPlay, 0, 1, 0, 0, 0);
        hoop_b[0] = 1;
        run("a_hit_pending", 0, 6, StPlay, 0, 1, 0, 0, 0);
        run("a_hit_on_last_tick", 0, 1, StCommit, 1, 0, 1, 1, 1);
        for (int i = 0; i < 7; i++) run("a_commit_stable", 0, 1, StCommit, 1, 0, 1, 1, 1);
        hoop_b[0] = 0;
        run("a_commit_hoop_low", 0, 6, StCommit, 1, 0, 1, 1, 1);
        hoop_b[0] = 1;
        run("a_commit_hit_ign", 0, 8, StCommit, 1, 0, 1, 1, 1);
        lb_rdy[0] = 1;
        run("a_done", 0, 1, StDone, 1, 0, 0, 0, 0);
        lb_rdy[0] = 0; hoop_b[0] = 0;
        run("a_done_hoop_low", 0, 6, StDone, 1, 0, 0, 0, 0);
        hoop_b[0] = 1;
        run("a_done_hit_ign", 0, 8, StDone, 1, 0, 0, 0, 0);
        hoop_b[0] = 0; start_b[0] = 0;
        run("a_done_idle", 0, 8, StDone, 1, 0, 0, 0, 0);

        // Reset in the middle of PLAY aborts without a commit.
        start_b[0] = 1;
        run("b_ready", 0, 3, StReady, 0, 2, 0, 0, 0);
        run("b_play", 0, 20, StPlay, 0, 3, 0, 0, 0);
        hoop_b[0] = 1;
        run("b_hit1", 0, 8, StPlay, 1, 3, 0, 0, 0);
        hoop_b[0] = 0;
        run("b_low", 0, 6, StPlay, 1, 2, 0, 0, 0);
        hoop_b[0] = 1;
        run("b_hit2", 0, 8, StPlay, 2, 1, 0, 0, 0);
        rst_n[0] = 0; start_b[0] = 0; hoop_b[0] = 0;
        run("b_reset_mid_play", 0, 1, StIdle, 0, 3, 0, 1, 0);
        rst_n[0] = 1;
        run("b_no_commit", 0, 12, StIdle, 0, 3, 0, 1, 0);

        // lb_ready already high on COMMIT entry: exactly one valid cycle.
        lb_rdy[0] = 1; start_b[0] = 1;
        run("c_ready", 0, 3, StReady, 0, 2, 0, 1, 0);
        run("c_play_last", 0, 49, StPlay, 0, 1, 0, 1, 0);
        run("c_commit_1cyc", 0, 1, StCommit, 0, 0, 1, 1, 0);
        run("c_done_next", 0, 1, StDone, 0, 0, 0, 0, 0);

        // Five clean 8-cycle hits plus a 2-cycle glitch.
        run("t3_reset", 1, 2, StIdle, 0, 3, 0, 1, 0);
        rst_n[1] = 1; start_b[1] = 1;
        run("t3_ready", 1, 3, StReady, 0, 2, 0, 1, 0);
        run("t3_play", 1, 200, StPlay, 0, 3, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            hoop_b[1] = 1;
            repeat (8) @(negedge clock);
            hoop_b[1] = 0;
            run("t3_hit", 1, 8, StPlay, i + 1, 3, 0, 1, 0);
        end
        hoop_b[1] = 1;
        repeat (2) @(negedge clock);
        hoop_b[1] = 0;
        run("t3_glitch", 1, 8, StPlay, 5, 3, 0, 1, 0);
        run("t3_commit", 1, 210, StCommit, 5, 0, 1, 1, 5);
        lb_rdy[1] = 1;
        run("t3_done", 1, 1, StDone, 5, 0, 0, 0, 0);

        // 300 hits with DEBOUNCE_CYC=1: score sticks at 255.
        rst_n[2] = 1; start_b[2] = 1;
        run("t6_ready", 2, 3, StReady, 0, 2, 0, 1, 0);
        run("t6_play", 2, 800, StPlay, 0, 5, 0, 1, 0);
        for (int i = 0; i < 300; i++) begin
            hoop_b[2] = 1;
            repeat (2) @(negedge clock);
            hoop_b[2] = 0;
            repeat (2) @(negedge clock);
            if (i == 99) run("t6_100_hits", 2, 0, StPlay, 100, 4, 0, 1, 0);
        end
        run("t6_saturated", 2, 8, StPlay, 255, 2, 0, 1, 0);
        run("t6_commit", 2, 792, StCommit, 255, 0, 1, 1, 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
